// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command responder.
// Frame states, command-byte layout and default status byte.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  localparam int CMD_RW_BIT = 7;
  localparam int SPI_BYTE_W = 8;

  localparam logic [SPI_BYTE_W-1:0] STATUS_BYTE_DEF = 8'hA5;
endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with
// single-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);
  logic [2:0] r_sh;

  // Reset to 0 so a line already low after reset shows no fall.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_sh <= '0;
    else       r_sh <= {r_sh[1:0], i_async};
  end

  assign o_rise = r_sh[1] & ~r_sh[2];
  assign o_fall = ~r_sh[1] & r_sh[2];
endmodule

// File: rtl/spi_cmd_responder.sv
// SPI mode-0 target serving a register file through a
// command/address protocol, plus a local read/write port.
module spi_cmd_responder
  import spi_pkg::*;
#(
  parameter int              DEPTH       = 16,
  parameter int              ADDR_W      = 4,
  parameter logic [7:0]      STATUS_BYTE = STATUS_BYTE_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              SCK,
  input  logic              SS,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  input  logic [ADDR_W-1:0] LB_ADDR,
  output logic [7:0]        LB_RDATA,
  input  logic              LB_WE,
  input  logic [7:0]        LB_WDATA,
  output logic              WR_PULSE,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  output logic              BUSY,
  output logic              ERR
);
  localparam logic [7:0] DEPTH8 = 8'(DEPTH);

  state_t r_state;
  state_t w_next;

  logic [7:0]        r_regs [DEPTH];
  logic [7:0]        r_rx;
  logic [7:0]        r_tx;
  logic [2:0]        r_bitcnt;
  logic              r_rw;
  logic              r_bad;
  logic              r_pend;
  logic [ADDR_W-1:0] r_addr;
  logic              r_miso;
  logic              r_oe;
  logic              r_wr_pulse;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_err;
  logic              r_mosi_meta;
  logic              r_mosi_sync;

  logic              w_sck_rise;
  logic              w_sck_fall;
  logic              w_ss_rise;
  logic              w_ss_fall;
  logic              w_act;
  logic              w_rise;
  logic              w_fall;
  logic [7:0]        w_rx_byte;
  logic [6:0]        w_cmd_addr;
  logic              w_cmd_bad;
  logic              w_byte_done;
  logic              w_commit;
  logic              w_load;
  logic [7:0]        w_load_byte;
  logic              w_local_we;

  spi_sync_edge u_sck (
    .i_clk   (PCLK),
    .i_rst   (PRESET),
    .i_async (SCK),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  spi_sync_edge u_ss (
    .i_clk   (PCLK),
    .i_rst   (PRESET),
    .i_async (SS),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= MOSI;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  // SCK edges only count inside a frame that is not closing.
  assign w_act       = (r_state != IDLE) && !w_ss_rise;
  assign w_rise      = w_act && w_sck_rise;
  assign w_fall      = w_act && w_sck_fall;
  assign w_rx_byte   = {r_rx[6:0], r_mosi_sync};
  assign w_cmd_addr  = w_rx_byte[6:0];
  assign w_cmd_bad   = {1'b0, w_cmd_addr} >= DEPTH8;
  assign w_byte_done = w_rise && (r_bitcnt == 3'd7);
  assign w_commit    = w_byte_done && (r_state == DATA)
                    && !r_rw && !r_bad;
  assign w_load      = w_fall && r_pend;
  assign w_load_byte = (r_rw && !r_bad) ? r_regs[r_addr]
                                        : 8'h00;
  assign w_local_we  = LB_WE
                    && !(w_commit && (LB_ADDR == r_addr));

  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_ss_fall) w_next = CMD;
      CMD:     if (w_load)    w_next = DATA;
      DATA:    w_next = DATA;
      default: w_next = IDLE;
    endcase
    if (w_ss_rise) w_next = IDLE;
  end

  always_comb begin
    BUSY = 1'b1;
    unique case (r_state)
      IDLE:    BUSY = 1'b0;
      default: BUSY = 1'b1;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_rx       <= '0;
      r_tx       <= '0;
      r_bitcnt   <= '0;
      r_rw       <= 1'b0;
      r_bad      <= 1'b0;
      r_pend     <= 1'b0;
      r_addr     <= '0;
      r_miso     <= 1'b0;
      r_oe       <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wr_pulse <= 1'b0;
      r_err      <= 1'b0;
      if (w_ss_rise) begin
        r_miso <= 1'b0;
        r_oe   <= 1'b0;
        r_pend <= 1'b0;
      end else if (r_state == IDLE) begin
        if (w_ss_fall) begin
          r_tx     <= {STATUS_BYTE[6:0], 1'b0};
          r_miso   <= STATUS_BYTE[7];
          r_oe     <= 1'b1;
          r_bitcnt <= '0;
          r_rw     <= 1'b0;
          r_bad    <= 1'b0;
          r_pend   <= 1'b0;
        end
      end else begin
        if (w_rise) begin
          r_rx     <= w_rx_byte;
          r_bitcnt <= r_bitcnt + 3'd1;
          if (w_byte_done) begin
            r_pend <= 1'b1;
            if (r_state == CMD) begin
              r_rw   <= w_rx_byte[CMD_RW_BIT];
              r_addr <= w_cmd_addr[ADDR_W-1:0];
              r_bad  <= w_cmd_bad;
              r_err  <= w_cmd_bad;
            end else begin
              r_addr <= r_addr + 1'b1;
              if (w_commit) begin
                r_wr_pulse <= 1'b1;
                r_wr_addr  <= r_addr;
                r_wr_data  <= w_rx_byte;
              end
            end
          end
        end
        // Read data is captured here, at byte load.
        if (w_load) begin
          r_tx   <= {w_load_byte[6:0], 1'b0};
          r_miso <= w_load_byte[7];
          r_pend <= 1'b0;
        end else if (w_fall) begin
          r_tx   <= {r_tx[6:0], 1'b0};
          r_miso <= r_tx[7];
        end
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      if (w_local_we) r_regs[LB_ADDR] <= LB_WDATA;
      if (w_commit)   r_regs[r_addr]  <= w_rx_byte;
    end
  end

  assign LB_RDATA = r_regs[LB_ADDR];
  assign MISO     = r_miso;
  assign MISO_OE  = r_oe;
  assign WR_PULSE = r_wr_pulse;
  assign WR_ADDR  = r_wr_addr;
  assign WR_DATA  = r_wr_data;
  assign ERR      = r_err;
endmodule

// File: tb/tb_spi_cmd_responder.sv
// Directed and randomized frames for spi_cmd_responder,
// checked against a byte-level model of the register file.
module tb_spi_cmd_responder;
  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       SCK;
  logic       SS;
  logic       MOSI;
  logic       MISO;
  logic       MISO_OE;
  logic [3:0] LB_ADDR;
  logic [7:0] LB_RDATA;
  logic       LB_WE;
  logic [7:0] LB_WDATA;
  logic       WR_PULSE;
  logic [3:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic       BUSY;
  logic       ERR;

  int nerr = 0;
  int nchk = 0;
  logic [7:0]  m [16];
  logic [11:0] wq[$];
  int          errs_seen = 0;

  spi_cmd_responder dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .SCK      (SCK),
    .SS       (SS),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .MISO_OE  (MISO_OE),
    .LB_ADDR  (LB_ADDR),
    .LB_RDATA (LB_RDATA),
    .LB_WE    (LB_WE),
    .LB_WDATA (LB_WDATA),
    .WR_PULSE (WR_PULSE),
    .WR_ADDR  (WR_ADDR),
    .WR_DATA  (WR_DATA),
    .BUSY     (BUSY),
    .ERR      (ERR)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (WR_PULSE) wq.push_back({WR_ADDR, WR_DATA});
    if (ERR) errs_seen++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    nchk++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int a = 0; a < 16; a++) begin
      LB_ADDR = 4'(a);
      #1;
      chk($sformatf("%s reg%0d", tag, a), LB_RDATA, m[a]);
    end
  endtask

  task automatic sck_bit(input logic b, output logic so);
    MOSI = b;
    tick(4);
    so = MISO;
    SCK = 1'b1;
    tick(4);
    SCK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    logic so;
    for (int b = 7; b >= 0; b--) sck_bit(v[b], so);
  endtask

  task automatic spi_xfer(input logic [7:0] tx[$],
                          input int nbits,
                          output logic [7:0] rx[$]);
    logic [7:0] sh;
    logic so;
    sh = '0;
    rx = {};
    SS = 1'b0;
    tick(2);
    chk("oe_lat_pre", MISO_OE, 0);
    tick(1);
    chk("oe_lat", MISO_OE, 1);
    chk("busy_on", BUSY, 1);
    for (int i = 0; i < nbits; i++) begin
      sck_bit(tx[i/8][7-(i%8)], so);
      sh = {sh[6:0], so};
      if (i % 8 == 7) rx.push_back(sh);
    end
    tick(4);
    SS = 1'b1;
    tick(3);
    chk("busy_off", BUSY, 0);
    chk("oe_off", MISO_OE, 0);
    chk("miso_off", MISO, 0);
    tick(3);
  endtask

  task automatic frame(input string tag,
                       input logic [7:0] tx[$],
                       input int nbits);
    logic [7:0]  rx[$];
    logic [7:0]  ex_miso[$];
    logic [11:0] ex_wr[$];
    int ex_err, nfull, a, cur, wbase, ebase;
    logic rw, bad;
    ex_err = 0;
    nfull  = nbits / 8;
    if (nfull > 0) begin
      rw  = tx[0][7];
      a   = int'(tx[0][6:0]);
      bad = (a >= 16);
      ex_err = bad ? 1 : 0;
      cur = a % 16;
      ex_miso.push_back(8'hA5);
      for (int k = 1; k < nfull; k++) begin
        ex_miso.push_back((rw && !bad) ? m[cur] : 8'h00);
        if (!rw && !bad) begin
          m[cur] = tx[k];
          ex_wr.push_back({4'(cur), tx[k]});
        end
        cur = (cur + 1) % 16;
      end
    end
    wbase = wq.size();
    ebase = errs_seen;
    spi_xfer(tx, nbits, rx);
    for (int k = 0; k < ex_miso.size(); k++)
      chk($sformatf("%s miso%0d", tag, k), rx[k], ex_miso[k]);
    chk({tag, " nwr"}, wq.size() - wbase, ex_wr.size());
    for (int k = 0; k < ex_wr.size(); k++)
      if (wbase + k < wq.size())
        chk($sformatf("%s wr%0d", tag, k), wq[wbase+k], ex_wr[k]);
    chk({tag, " err"}, errs_seen - ebase, ex_err);
    check_regs(tag);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] v;
    int wbase, nb, len;
    PRESET = 1'b1;
    SCK = 1'b0;
    SS = 1'b1;
    MOSI = 1'b0;
    LB_WE = 1'b0;
    LB_ADDR = '0;
    LB_WDATA = '0;
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    tick(3);
    chk("rst miso", MISO, 0);
    chk("rst oe", MISO_OE, 0);
    chk("rst busy", BUSY, 0);
    chk("rst wrp", WR_PULSE, 0);
    chk("rst err", ERR, 0);
    PRESET = 1'b0;
    tick(3);
    check_regs("rst");

    q = {8'h03, 8'h11, 8'h22};
    frame("wr1", q, 24);
    q = {8'h83, 8'h00, 8'h00};
    frame("rd1", q, 24);
    q = {8'h0F, 8'hAA, 8'hBB};
    frame("wrap_wr", q, 24);
    q = {8'h8F, 8'h00, 8'h00};
    frame("wrap_rd", q, 24);
    q = {8'h20, 8'h55};
    frame("bad_wr", q, 16);
    q = {8'hA0, 8'h00, 8'h00};
    frame("bad_rd", q, 24);
    q = {8'h05, 8'hF0};
    frame("abort", q, 12);
    q = {8'h85, 8'h00};
    frame("post_abort", q, 16);

    // Local write held across the SPI commit edge for addr 2.
    wbase = wq.size();
    SS = 1'b0;
    tick(4);
    send_byte(8'h02);
    v = 8'h3C;
    for (int b = 7; b >= 1; b--) begin
      logic so;
      sck_bit(v[b], so);
    end
    MOSI = v[0];
    tick(4);
    SCK = 1'b1;
    LB_ADDR = 4'd2;
    LB_WDATA = 8'h99;
    LB_WE = 1'b1;
    tick(3);
    LB_WE = 1'b0;
    tick(1);
    SCK = 1'b0;
    tick(4);
    SS = 1'b1;
    tick(6);
    m[2] = 8'h3C;
    chk("coll nwr", wq.size() - wbase, 1);
    if (wq.size() > wbase)
      chk("coll wr", wq[wbase], {4'd2, 8'h3C});
    check_regs("coll");

    // Reset mid-byte with SS held low afterwards.
    SS = 1'b0;
    tick(4);
    send_byte(8'h83);
    send_byte(8'h00);
    v = 8'hE0;
    for (int b = 7; b >= 5; b--) begin
      logic so;
      sck_bit(v[b], so);
    end
    PRESET = 1'b1;
    tick(1);
    chk("mrst busy", BUSY, 0);
    chk("mrst oe", MISO_OE, 0);
    chk("mrst miso", MISO, 0);
    chk("mrst wraddr", WR_ADDR, 0);
    chk("mrst wrdata", WR_DATA, 0);
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    check_regs("mrst");
    PRESET = 1'b0;
    tick(2);
    wbase = wq.size();
    send_byte(8'h03);
    send_byte(8'h77);
    chk("held busy", BUSY, 0);
    chk("held oe", MISO_OE, 0);
    chk("held nwr", wq.size() - wbase, 0);
    SS = 1'b1;
    tick(6);
    check_regs("held");
    q = {8'h04, 8'h5A};
    frame("post_rst", q, 16);

    for (int r = 0; r < 10; r++) begin
      int la;
      la = int'($urandom_range(0, 15));
      LB_ADDR = 4'(la);
      LB_WDATA = 8'($urandom);
      LB_WE = 1'b1;
      tick(1);
      LB_WE = 1'b0;
      m[la] = LB_WDATA;
      len = int'($urandom_range(1, 3));
      q = {};
      q.push_back({1'($urandom), 7'($urandom_range(0, 19))});
      for (int k = 0; k < len; k++) q.push_back(8'($urandom));
      nb = 8 * (len + 1);
      frame($sformatf("rnd%0d", r), q, nb);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
